regfile_mp: RTL and testbench

//  Parametrised multi-read-port register file for the RISC-V core datapath; successor to the 2R1W 32x32 file.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_rd_port.sv | 39 +++
 rtl/regfile_mp.sv | 137 +++++++++++++
 tb/tb_regfile_mp.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the multi-port register file.
// Holds the clear-engine state encoding and the hardwired-zero register address.
package regfile_pkg;

  // Sequential clear engine states
  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_e;

  // Address of the architectural zero register x0
  localparam int X0_ADDR = 0;

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one combinational read port of the register file.
// Address x0 always reads zero. With REGFILE_BYPASS_EN defined, a write
// accepted in the same cycle to the same address is forwarded to the output.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic [NREG-1:0][XLEN-1:0] regs,
  input  logic [AW-1:0]             raddr,
  output logic [XLEN-1:0]           rdata
`ifdef REGFILE_BYPASS_EN
  ,
  input  logic                      wr_en,
  input  logic [AW-1:0]             waddr,
  input  logic [XLEN-1:0]           wdata
`endif
);

  // Read mux: x0 forced to zero, optional write-through forwarding, else stored value
  always_comb begin
    rdata = {XLEN{1'b0}};
    if (raddr == AW'(X0_ADDR)) begin
      rdata = {XLEN{1'b0}};
    end
`ifdef REGFILE_BYPASS_EN
    // wr_en already excludes x0 and clear-engine activity
    else if (wr_en && (raddr == waddr)) begin
      rdata = wdata;
    end
`endif
    else begin
      rdata = regs[raddr];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file with hardwired-zero x0,
// asynchronous reset and a sequential clear engine (one register per cycle).
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  output logic                wr_ready,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done
);

  clr_state_e state_r, state_s;
  logic [AW-1:0] ptr_r, ptr_s;
  logic clr_busy_r, clr_done_r, wr_ready_r;
  logic wr_en_s;
  logic clr_wipe_s;

  // x0 is not stored; only registers 1..NREG-1 have flops
  logic [XLEN-1:0] regs_r [NREG-1:1];
  logic [NREG-1:0][XLEN-1:0] regs_view_s;

  assign wr_ready = wr_ready_r;
  assign clr_busy = clr_busy_r;
  assign clr_done = clr_done_r;

  // A write lands only when accepted and not aimed at x0
  assign wr_en_s    = we && wr_ready_r && (waddr != AW'(X0_ADDR));
  assign clr_wipe_s = (state_r == CLR_CLEAR);

  // Clear FSM state, pointer and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= CLR_IDLE;
      ptr_r      <= {AW{1'b0}};
      clr_busy_r <= 1'b0;
      clr_done_r <= 1'b0;
      wr_ready_r <= 1'b1;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      clr_busy_r <= (state_s != CLR_IDLE);
      clr_done_r <= (state_s == CLR_DONE);
      wr_ready_r <= (state_s == CLR_IDLE);
    end
  end

  // Clear FSM next state: terminal check precedes increment so ptr never wraps
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    case (state_r)
      CLR_IDLE: begin
        if (clr_req) begin
          state_s = CLR_CLEAR;
          ptr_s   = AW'(1);
        end else begin
          state_s = CLR_IDLE;
        end
      end
      CLR_CLEAR: begin
        if (ptr_r == AW'(NREG - 1)) begin
          state_s = CLR_DONE;
        end else begin
          ptr_s = ptr_r + AW'(1);
        end
      end
      CLR_DONE: begin
        state_s = CLR_IDLE;
      end
      default: begin
        state_s = CLR_IDLE;
        ptr_s   = {AW{1'b0}};
      end
    endcase
  end

  // Storage: async reset, clear engine wipes ptr, otherwise accepted writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (clr_wipe_s && (ptr_r == AW'(i))) begin
          regs_r[i] <= {XLEN{1'b0}};
        end else if (wr_en_s && (waddr == AW'(i))) begin
          regs_r[i] <= wdata;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end
  end

  // Flat view for the read muxes with a constant-zero slot for x0
  always_comb begin
    regs_view_s[0] = {XLEN{1'b0}};
    for (int i = 1; i < NREG; i++) begin
      regs_view_s[i] = regs_r[i];
    end
  end

  generate
    for (genvar k = 0; k < NRD; k++) begin : g_rd
      regfile_rd_port #(
        .XLEN(XLEN),
        .NREG(NREG),
        .AW  (AW)
      ) u_rd_port (
        .regs (regs_view_s),
        .raddr(raddr[k*AW +: AW]),
        .rdata(rdata[k*XLEN +: XLEN])
`ifdef REGFILE_BYPASS_EN
        ,
        .wr_en(wr_en_s),
        .waddr(waddr),
        .wdata(wdata)
`endif
      );
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized self-checking bench for regfile_mp against a
// behavioural array model; directed checks for reset, x0, same-cycle
// read/write, full clear and reset during clear.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                we;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wdata;
  logic                wr_ready;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic                clr_req;
  logic                clr_busy;
  logic                clr_done;

  // reference model: architectural register contents and "clear engine active"
  logic [XLEN-1:0] mem [NREG];
  bit              mbusy;
  int              n_vec = 0;
  int              n_err = 0;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .wr_ready(wr_ready), .raddr(raddr), .rdata(rdata),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [XLEN-1:0] got,
                           input logic [XLEN-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_read(input int k);
    logic [AW-1:0] a;
    a = raddr[k*AW +: AW];
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && !mbusy && waddr != 0 && waddr == a) return wdata;
`endif
    return mem[a];
  endfunction

  task automatic check_reads(input string tag);
    for (int k = 0; k < NRD; k++) check_val(tag, rdata[k*XLEN +: XLEN], exp_read(k));
  endtask

  task automatic check_flags(input string tag, input logic busy, input logic done);
    check_val({tag, "_busy"}, {31'd0, clr_busy}, {31'd0, busy});
    check_val({tag, "_done"}, {31'd0, clr_done}, {31'd0, done});
    check_val({tag, "_wrrdy"}, {31'd0, wr_ready}, {31'd0, ~busy});
  endtask

  // one clock edge; model commits accepted writes, then step off the edge
  task automatic cycle();
    @(posedge clk);
    if (we && !mbusy && waddr != 0) mem[waddr] = wdata;
    #1;
  endtask

  task automatic set_rd(input int k, input int a);
    raddr[k*AW +: AW] = AW'(a);
  endtask

  // sweep every address over every port, comparing against the model
  task automatic check_all(input string tag);
    for (int a = 0; a < NREG; a++) begin
      for (int k = 0; k < NRD; k++) set_rd(k, (a + k) % NREG);
      #1;
      check_reads(tag);
    end
  endtask

  task automatic write_reg(input int a, input logic [XLEN-1:0] d);
    we = 1'b1; waddr = AW'(a); wdata = d;
    cycle();
    we = 1'b0;
  endtask

  task automatic start_clear();
    clr_req = 1'b1; we = 1'b0;
    cycle();
    clr_req = 1'b0;
    mbusy = 1'b1;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0; clr_req = 1'b0;
    mbusy = 1'b0;
    for (int i = 0; i < NREG; i++) mem[i] = '0;
    #12;
    check_flags("rst_init", 1'b0, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // 1: writes, then reset pulse clears everything
    for (int i = 1; i < 6; i++) write_reg(i, $urandom);
    check_all("pre_rst");
    @(negedge clk); rst = 1'b1; #1;
    for (int i = 0; i < NREG; i++) mem[i] = '0;
    check_flags("rst_pulse", 1'b0, 1'b0);
    check_all("rst_reads");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // 2: write then read on next cycle
    write_reg(5, 32'hDEADBEEF);
    set_rd(0, 5); set_rd(1, 0); #1;
    check_val("wr5_rd0", rdata[0 +: XLEN], 32'hDEADBEEF);
    check_val("wr5_rd1", rdata[XLEN +: XLEN], 32'h0);

    // 3: write to x0 is discarded
    write_reg(0, 32'h00001234);
    set_rd(0, 0); set_rd(1, 0); #1;
    check_val("x0_rd0", rdata[0 +: XLEN], 32'h0);
    check_val("x0_rd1", rdata[XLEN +: XLEN], 32'h0);

    // 4: same-cycle write and read of register 7
    write_reg(7, 32'h11111111);
    we = 1'b1; waddr = AW'(7); wdata = 32'hA5A5A5A5;
    set_rd(0, 7); set_rd(1, 7); #1;
`ifdef REGFILE_BYPASS_EN
    check_val("samecyc_rd0", rdata[0 +: XLEN], 32'hA5A5A5A5);
`else
    check_val("samecyc_rd0", rdata[0 +: XLEN], 32'h11111111);
`endif
    check_reads("samecyc_model");
    cycle();
    we = 1'b0; #1;
    check_val("samecyc_after", rdata[0 +: XLEN], 32'hA5A5A5A5);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      we    = 1'($urandom);
      waddr = AW'($urandom);
      wdata = $urandom;
      for (int k = 0; k < NRD; k++) set_rd(k, ($urandom_range(0, 3) == 0) ? int'(waddr) : int'($urandom_range(0, NREG-1)));
      #1;
      check_reads("rand");
      cycle();
    end
    we = 1'b0;

    // 5: fill 1..NREG-1, run a full clear; CLEAR lasts NREG-1 cycles, then one DONE cycle
    for (int i = 1; i < NREG; i++) write_reg(i, $urandom | 32'h1);
    start_clear();
    for (int j = 0; j < NREG - 1; j++) begin
      we = 1'b1; waddr = AW'($urandom_range(1, NREG-1)); wdata = $urandom;
      set_rd(0, j + 1); set_rd(1, j); #1;
      check_flags("clr_run", 1'b1, 1'b0);
      check_reads("clr_rd");
      cycle();
      mem[j + 1] = '0;
    end
    we = 1'b1; waddr = AW'(3); wdata = 32'hFFFFFFFF; #1;
    check_flags("clr_done_cyc", 1'b1, 1'b1);
    cycle();
    we = 1'b0; mbusy = 1'b0; #1;
    check_flags("clr_after", 1'b0, 1'b0);
    check_all("clr_all_zero");

    // 6: reset asserted when ptr reaches 10
    for (int i = 1; i < NREG; i++) write_reg(i, $urandom | 32'h1);
    start_clear();
    for (int j = 0; j < 9; j++) begin
      cycle();
      mem[j + 1] = '0;
    end
    check_flags("mid_clr", 1'b1, 1'b0);
    rst = 1'b1; #1;
    mbusy = 1'b0;
    for (int i = 0; i < NREG; i++) mem[i] = '0;
    check_flags("mid_rst", 1'b0, 1'b0);
    check_all("mid_rst_reads");
    @(negedge clk); rst = 1'b0;
    for (int n = 0; n < 40; n++) begin
      cycle();
      check_val("no_done_pulse", {31'd0, clr_done}, 32'd0);
    end
    check_all("post_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
